// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit owning the HI/LO pair for the EX stage.
// Optional MADD/MSUB accumulate (op 110/111) is enabled by defining MD_MADD_EN.
module md_unit #(
    parameter int unsigned MUL_CYCLES = 5,
    parameter int unsigned DIV_CYCLES = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int unsigned MAX_CYCLES = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int unsigned CNT_W      = (MAX_CYCLES < 2) ? 1 : $clog2(MAX_CYCLES + 1);
    localparam int unsigned DW         = 32;

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;
`ifdef MD_MADD_EN
    localparam logic [2:0] OP_MADD  = 3'b110;
    localparam logic [2:0] OP_MSUB  = 3'b111;
`endif

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q,   cnt_d;
    logic [2*DW-1:0]    pend_q,  pend_d;
    logic [DW-1:0]      hi_q,    hi_d;
    logic [DW-1:0]      lo_q,    lo_d;

`ifdef MD_MADD_EN
    typedef enum logic [1:0] {
        PM_LOAD = 2'd0,
        PM_ADD  = 2'd1,
        PM_SUB  = 2'd2
    } pmode_t;

    pmode_t             mode_q,  mode_d;
`endif

    // Full-width products; sign extension makes the low 64 bits the signed product.
    logic [2*DW-1:0] a_sx, b_sx, prod_s, prod_u;

    assign a_sx   = {{DW{A[DW-1]}}, A};
    assign b_sx   = {{DW{B[DW-1]}}, B};
    assign prod_s = a_sx * b_sx;
    assign prod_u = {{DW{1'b0}}, A} * {{DW{1'b0}}, B};

    // One unsigned divider shared by DIV/DIVU; signed DIV works on magnitudes.
    logic          div_signed;
    logic [DW-1:0] num, den, den_safe, q_mag, r_mag, quot, rem;

    assign div_signed = (op == OP_DIV);
    assign num        = (div_signed && A[DW-1]) ? (DW'(0) - A) : A;
    assign den        = (div_signed && B[DW-1]) ? (DW'(0) - B) : B;
    assign den_safe   = (B == DW'(0)) ? DW'(1) : den;
    assign q_mag      = num / den_safe;
    assign r_mag      = num % den_safe;

    // Restore signs; 0x80000000 / -1 falls out naturally as 0x80000000 rem 0.
    always_comb begin
        quot = q_mag;
        rem  = r_mag;
        if (B == DW'(0)) begin
            quot = '1;
            rem  = A;
        end else if (div_signed) begin
            if (A[DW-1] ^ B[DW-1]) begin
                quot = DW'(0) - q_mag;
            end
            if (A[DW-1]) begin
                rem = DW'(0) - r_mag;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            pend_q  <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
`ifdef MD_MADD_EN
            mode_q  <= PM_LOAD;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
`ifdef MD_MADD_EN
            mode_q  <= mode_d;
`endif
        end
    end

    // Accept/countdown/commit; any start while busy is ignored.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pend_d  = pend_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
`ifdef MD_MADD_EN
        mode_d  = mode_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (start) begin
`ifdef MD_MADD_EN
                    mode_d = PM_LOAD;
`endif
                    case (op)
                        OP_MULT: begin
                            pend_d  = prod_s;
                            cnt_d   = CNT_W'(MUL_CYCLES);
                            state_d = ST_BUSY;
                        end
                        OP_MULTU: begin
                            pend_d  = prod_u;
                            cnt_d   = CNT_W'(MUL_CYCLES);
                            state_d = ST_BUSY;
                        end
                        OP_DIV, OP_DIVU: begin
                            pend_d  = {rem, quot};
                            cnt_d   = CNT_W'(DIV_CYCLES);
                            state_d = ST_BUSY;
                        end
                        OP_MTHI: hi_d = A;
                        OP_MTLO: lo_d = A;
`ifdef MD_MADD_EN
                        OP_MADD: begin
                            pend_d  = prod_s;
                            mode_d  = PM_ADD;
                            cnt_d   = CNT_W'(MUL_CYCLES);
                            state_d = ST_BUSY;
                        end
                        OP_MSUB: begin
                            pend_d  = prod_s;
                            mode_d  = PM_SUB;
                            cnt_d   = CNT_W'(MUL_CYCLES);
                            state_d = ST_BUSY;
                        end
`endif
                        default: ;
                    endcase
                end
            end

            ST_BUSY: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = ST_IDLE;
`ifdef MD_MADD_EN
                    // Accumulate against HI/LO as they stand at commit.
                    case (mode_q)
                        PM_ADD:  {hi_d, lo_d} = {hi_q, lo_q} + pend_q;
                        PM_SUB:  {hi_d, lo_d} = {hi_q, lo_q} - pend_q;
                        default: {hi_d, lo_d} = pend_q;
                    endcase
`else
                    {hi_d, lo_d} = pend_q;
`endif
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    assign busy = (state_q == ST_BUSY);
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_md_unit.sv
// Scoreboard bench for md_unit: a driver issues ops and queues model results,
// a monitor checks HI/LO, busy length and HI/LO hold on every commit.
module tb_md_unit;

    localparam int unsigned MUL_N = 5;
    localparam int unsigned DIV_N = 10;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  op    = 3'd0;
    logic [31:0] A     = 32'd0;
    logic [31:0] B     = 32'd0;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    md_unit #(
        .MUL_CYCLES (MUL_N),
        .DIV_CYCLES (DIV_N)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .op    (op),
        .A     (A),
        .B     (B),
        .busy  (busy),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit          imm;
        int unsigned due;
        logic [31:0] hi;
        logic [31:0] lo;
        logic [31:0] old_hi;
        logic [31:0] old_lo;
        int unsigned lat;
    } exp_t;

    exp_t        sbq[$];
    int          errors = 0;
    int          checks = 0;
    logic [31:0] ref_hi = 32'd0;
    logic [31:0] ref_lo = 32'd0;
    bit          abort  = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%h required=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Architectural reference: results straight from the op definitions.
    function automatic exp_t model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                                   input logic [31:0] chi, input logic [31:0] clo);
        exp_t              e;
        int                sa;
        int                sb;
        longint            p;
        longint unsigned   ua;
        longint unsigned   ub;
        longint unsigned   acc;
        sa = a;
        sb = b;
        ua = a;
        ub = b;
        e.imm = 1'b1; e.due = 0; e.lat = 0;
        e.hi = chi; e.lo = clo; e.old_hi = chi; e.old_lo = clo;
        case (o)
            3'd0: begin
                p = longint'(sa) * longint'(sb);
                {e.hi, e.lo} = p;
                e.imm = 1'b0; e.lat = MUL_N;
            end
            3'd1: begin
                acc = ua * ub;
                {e.hi, e.lo} = acc;
                e.imm = 1'b0; e.lat = MUL_N;
            end
            3'd2: begin
                if (b == 32'd0) begin
                    e.lo = 32'hFFFF_FFFF; e.hi = a;
                end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    e.lo = 32'h8000_0000; e.hi = 32'd0;
                end else begin
                    e.lo = 32'(sa / sb); e.hi = 32'(sa % sb);
                end
                e.imm = 1'b0; e.lat = DIV_N;
            end
            3'd3: begin
                if (b == 32'd0) begin
                    e.lo = 32'hFFFF_FFFF; e.hi = a;
                end else begin
                    e.lo = a / b; e.hi = a % b;
                end
                e.imm = 1'b0; e.lat = DIV_N;
            end
            3'd4: e.hi = a;
            3'd5: e.lo = a;
`ifdef MD_MADD_EN
            3'd6, 3'd7: begin
                p   = longint'(sa) * longint'(sb);
                acc = {chi, clo};
                acc = (o == 3'd6) ? acc + longint unsigned'(p) : acc - longint unsigned'(p);
                {e.hi, e.lo} = acc;
                e.imm = 1'b0; e.lat = MUL_N;
            end
`endif
            default: ;
        endcase
        return e;
    endfunction

    task automatic wait_drain();
        for (int i = 0; i < 40 && sbq.size() > 0; i++) @(negedge clk);
        if (sbq.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: actual=%0d pending required=0", sbq.size());
            sbq.delete();
            abort = 1'b1;
        end
    endtask

    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        @(negedge clk);
        start = 1'b1; op = o; A = a; B = b;
        e = model(o, a, b, ref_hi, ref_lo);
        e.due = cyc + 1;
        sbq.push_back(e);
        ref_hi = e.hi;
        ref_lo = e.lo;
    endtask

    task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        issue(o, a, b);
        @(negedge clk);
        start = 1'b0;
        wait_drain();
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    // Monitor: commit = busy falling; immediate ops are checked one edge after issue.
    bit          prev_busy = 1'b0;
    int unsigned busy_cnt  = 0;
    bit          hold_bad  = 1'b0;

    always @(negedge clk) begin
        exp_t e;
        if (abort) begin
            abort     = 1'b0;
            prev_busy = 1'b0;
            busy_cnt  = 0;
            hold_bad  = 1'b0;
        end else if (rst_n) begin
            if (busy) begin
                busy_cnt++;
                if (sbq.size() > 0 && (hi !== sbq[0].old_hi || lo !== sbq[0].old_lo)) hold_bad = 1'b1;
            end else if (prev_busy) begin
                if (sbq.size() == 0 || sbq[0].imm) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_commit: actual hi=%h lo=%h required no commit", hi, lo);
                end else begin
                    e = sbq.pop_front();
                    chk("commit_hi", hi, e.hi);
                    chk("commit_lo", lo, e.lo);
                    chk("busy_len", 32'(busy_cnt), 32'(e.lat));
                    chk("hilo_hold", 32'(hold_bad), 32'd0);
                end
                busy_cnt = 0;
                hold_bad = 1'b0;
            end else if (sbq.size() > 0 && sbq[0].imm && cyc == sbq[0].due) begin
                e = sbq.pop_front();
                chk("imm_hi", hi, e.hi);
                chk("imm_lo", lo, e.lo);
                chk("imm_busy", 32'(busy), 32'd0);
            end
            prev_busy = busy;
        end
    end

    initial begin
        exp_t e;
        repeat (3) @(negedge clk);
        chk("rst_busy_in", 32'(busy), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);

        run_op(3'd0, 32'hFFFF_FFFE, 32'd3);
        run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_op(3'd2, 32'hFFFF_FFF9, 32'd2);
        run_op(3'd3, 32'd7, 32'd0);
        run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op(3'd2, 32'h8000_0005, 32'd0);
        run_op(3'd3, 32'hFFFF_FFF9, 32'd2);
        run_op(3'd5, 32'h1234_5678, 32'd0);

        // Second start during busy cycle 3 must be ignored.
        issue(3'd0, 32'h0001_2345, 32'hFFFF_F000);
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        start = 1'b1; op = 3'd2; A = 32'd1000; B = 32'd3;
        @(negedge clk);
        start = 1'b0;
        wait_drain();

        run_op(3'd4, 32'd0, 32'd0);
        run_op(3'd5, 32'hFFFF_FFFF, 32'd0);
        run_op(3'd6, 32'd1, 32'd1);
        run_op(3'd7, 32'd3, 32'hFFFF_FFFB);
        run_op(3'd4, 32'hCAFE_F00D, 32'd0);

        // Reset at busy cycle 4 of a DIV aborts it with no late commit.
        @(negedge clk);
        start = 1'b1; op = 3'd2; A = 32'd100; B = 32'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        abort = 1'b1;
        #1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_hi", hi, 32'd0);
        chk("abort_lo", lo, 32'd0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        ref_hi = 32'd0;
        ref_lo = 32'd0;
        repeat (12) @(negedge clk);
        chk("post_abort_hi", hi, 32'd0);
        chk("post_abort_lo", lo, 32'd0);
        chk("post_abort_busy", 32'(busy), 32'd0);

        for (int i = 0; i < 40; i++) begin
            logic [2:0]  o;
            logic [31:0] a;
            logic [31:0] b;
            o = 3'($urandom_range(0, 7));
            a = pick();
            b = pick();
            run_op(o, a, b);
        end

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
